// File: rtl/mult_div_unit.sv
// mult_div_unit: sequential signed multiply/divide responder for the MULT/DIV
// handshake. One multiplier/quotient bit per cycle on unsigned magnitudes,
// followed by a single sign-fix cycle that writes HI/LO.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    op,
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   output logic                    busy,
   output logic                    done,
   output logic                    div0,
   output logic        [WIDTH-1:0] hi,
   output logic        [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t             state, state_nxt;
   logic [CW-1:0]      cnt;
   logic               op_r, sign_a, sign_b;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [2*WIDTH-1:0] acc, acc_step, res;
   logic [WIDTH:0]     sum, shifted, trial;
   logic               accept, div_zero;

   // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1).
   function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
      logic [WIDTH-1:0] u;
      u = v;
      return v[WIDTH-1] ? (~u) + WIDTH'(1) : u;
   endfunction

   // Conditional negation of a single word.
   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic n);
      return n ? (~v) + WIDTH'(1) : v;
   endfunction

   // Conditional negation of a double word.
   function automatic logic [2*WIDTH-1:0] neg_dw(input logic [2*WIDTH-1:0] v, input logic n);
      return n ? (~v) + (2*WIDTH)'(1) : v;
   endfunction

   assign accept   = (state == IDLE) && start && !(op && (b == '0));
   assign div_zero = (state == IDLE) && start && op && (b == '0);

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic: WIDTH iterations in RUN, then one FIX cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = RUN;
         RUN:     if (cnt == CW'(WIDTH-1)) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // One iteration: shift-add (MULT, acc = {partial, multiplier}) or restoring
   // division (DIV, acc = {remainder, dividend/quotient}).
   always_comb begin
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
      shifted  = acc[2*WIDTH-1:WIDTH-1];
      trial    = shifted - {1'b0, mag_b};
      acc_step = acc;
      if (!op_r)
         acc_step = {sum, acc[WIDTH-1:1]};
      else if (trial[WIDTH])
         acc_step = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
         acc_step = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
   end

   // Sign fix: product by sign XOR; quotient by sign XOR, remainder by dividend sign.
   always_comb begin
      res = neg_dw(acc, sign_a ^ sign_b);
      if (op_r)
         res = {neg_w(acc[2*WIDTH-1:WIDTH], sign_a), neg_w(acc[WIDTH-1:0], sign_a ^ sign_b)};
   end

   // Operand capture, iteration datapath, result registers and status pulses.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt    <= '0;
         op_r   <= 1'b0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         mag_a  <= '0;
         mag_b  <= '0;
         acc    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         div0   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         done <= 1'b0;
         div0 <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  cnt    <= '0;
                  op_r   <= op;
                  sign_a <= a[WIDTH-1];
                  sign_b <= b[WIDTH-1];
                  mag_a  <= mag(a);
                  mag_b  <= mag(b);
                  acc    <= op ? {{WIDTH{1'b0}}, mag(a)} : {{WIDTH{1'b0}}, mag(b)};
                  busy   <= 1'b1;
               end else if (div_zero) begin
                  done <= 1'b1;
                  div0 <= 1'b1;
               end
            end
            RUN: begin
               acc <= acc_step;
               cnt <= cnt + CW'(1);
            end
            FIX: begin
               hi   <= res[2*WIDTH-1:WIDTH];
               lo   <= res[WIDTH-1:0];
               done <= 1'b1;
               busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Sequential signed multiply/divide unit for the multicycle MIPS datapath. It is the responder side of the control unit's MULT/DIV handshake. The control FSM pulses `start` with `op` selecting multiply or divide, then waits in its execute state until `done`. The unit then presents stable HI/LO results for the control FSM to commit with HILOWrite. A divide-by-zero is reported on `div0`, which feeds the control unit's exception path.

## Interface
Parameters:
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `op`  in  1  operation select, same encoding as the control unit's MDcontrol: 0 = MULT, 1 = DIV.
- `a`  in  WIDTH  rs operand (register A); multiplicand or dividend.
- `b`  in  WIDTH  rt operand (register B); multiplier or divisor.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse; `hi`/`lo` are valid from this cycle onward.
- `div0`  out  1  one-cycle pulse, coincident with `done`, on DIV with `b == 0`.
- `hi`  out  WIDTH  MULT: upper product word. DIV: remainder.
- `lo`  out  WIDTH  MULT: lower product word. DIV: quotient.

## Operation
- States: IDLE, RUN, FIX.
- Reset (async, `reset == 0`): state IDLE; iteration counter 0; `busy`, `done`, `div0` = 0; `hi`, `lo` = 0; internal registers cleared. Reset asserted mid-operation aborts the operation and leaves no partial result.
- IDLE, `start == 1`, and not (`op == 1` and `b == 0`):
  - Latch |a| and |b| and the operand sign bits.
  - Go to RUN with counter = 0.
- IDLE, `start == 1`, `op == 1`, `b == 0`:
  - Stay in IDLE.
  - Pulse `done` and `div0`.
  - `hi`/`lo` are unchanged.
- RUN, MULT: unsigned shift-add, one multiplier bit per cycle, into a 2·WIDTH accumulator.
- RUN, DIV: unsigned restoring division, one quotient bit per cycle (shift the partial remainder, trial subtract, restore on negative).
- RUN leaves for FIX after exactly WIDTH iterations.
- FIX, MULT: the product is negated if `a[W-1]` XOR `b[W-1]`. `hi` = upper word, `lo` = lower word.
- FIX, DIV:
  - The quotient is negated if the signs differ. The remainder takes the dividend's sign.
  - The quotient truncates toward zero (MIPS semantics).
- FIX writes `hi`/`lo`, pulses `done`, and returns to IDLE.
- Overflow −2^31 / −1: no exception. Result `lo` = 0x80000000, `hi` = 0.
- `start` in RUN or FIX is ignored; inputs are not re-sampled.
- `a`/`b` may change after the start edge without affecting the result.
- `hi`/`lo` hold their values until the next FIX or reset.

## Timing
- Start sampled at edge E0. Iterations run on E1..E32. FIX executes on E33.
- `done` is high in the cycle after E33 (33-edge latency for WIDTH = 32; generally WIDTH+1).
- `busy` is high in the cycles after E0 through E32, and low in the `done` cycle.
- The divide-by-zero path has 1-edge latency: `done` and `div0` are high in the cycle after E0, and `busy` stays low.
- Back-to-back: `start` high in the `done` cycle is accepted (the unit is already in IDLE).
- `done` and `div0` are registered and high for exactly one cycle. They are never asserted without a preceding accepted `start`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- MULT a=7, b=0xFFFFFFFD (−3) → `done` 33 edges after start; `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFEB.
- MULT a=0x80000000, b=0x80000000 → `hi` = 0x40000000, `lo` = 0x00000000; `busy` high for exactly 33 cycles.
- DIV a=0xFFFFFFF9 (−7), b=2 → `lo` = 0xFFFFFFFD (−3), `hi` = 0xFFFFFFFF (−1). Also DIV a=0x80000000, b=0xFFFFFFFF → `lo` = 0x80000000, `hi` = 0.
- DIV a=5, b=0 with prior `hi`/`lo` = 0x11/0x22 → `done` and `div0` high one cycle after start; `busy` stays 0; `hi`/`lo` still 0x11/0x22.
- MULT 3×4 started; second `start` with DIV 9/3 pulsed at E10 → ignored; result `lo` = 12, `hi` = 0. Then DIV 9/3 started in the `done` cycle → `lo` = 3, `hi` = 0 after 33 more edges.
- MULT started; `reset` driven low at E15 → immediately `busy` = 0, `hi` = `lo` = 0, no `done`. After release, a new MULT 2×2 completes with `lo` = 4.
